// File: rtl/hex_uart_printer_pkg.sv
// ============================================================================
// Module   : hex_uart_printer_pkg
// Brief    : Shared UART frame constants, ASCII codes, printer state type and
//            the nibble-to-ASCII conversion used by the hex printer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_uart_printer_pkg;

  // 8N1 frame: start bit, 8 data bits LSB first, stop bit
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   BITS_PER_FRAME = 10;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // 0-9 map to '0'-'9', 10-15 map to lowercase 'a'-'f' ('a' - 10 = 0x57)
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_uart_printer_if.sv
// ============================================================================
// Module   : hex_uart_printer_if
// Brief    : Word handshake plus UART pad signals of the hex printer.
//            master = word producer side, slave = printer side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hex_uart_printer_if #(
  parameter int WORD_NIBBLES = 4
);

  logic [4*WORD_NIBBLES-1:0] in_data;
  logic                      in_valid;
  logic                      in_ready;
  logic                      tx;
  logic                      busy;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  tx,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output tx,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/hex_uart_printer_uart_tx_byte.sv
// ============================================================================
// Module   : uart_tx_byte
// Brief    : 8N1 byte serialiser. ready_o is high when idle and also during
//            the last cycle of the stop bit, so a start in that cycle chains
//            the next frame with no idle gap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
  import hex_uart_printer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  input  wire logic       start_i,
  input  wire logic [7:0] data_i,
  output logic            tx_o,
  output logic            ready_o
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(BITS_PER_FRAME - 1);
  localparam logic [3:0]       BIT_MSB  = 4'd8;

  logic             active_q;
  logic             tx_q;
  logic [7:0]       data_q;
  logic [3:0]       bit_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready_o = ~active_q | (bit_end & (bit_idx_q == BIT_LAST));
  assign tx_o    = tx_q;

  // Bit timing and frame sequencing; tx is registered so reset forces the line idle at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      tx_q      <= STOP_BIT;
      data_q    <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
    end else if (ready_o && start_i) begin
      active_q  <= 1'b1;
      tx_q      <= START_BIT;
      data_q    <= data_i;
      bit_idx_q <= '0;
      cnt_q     <= '0;
    end else if (active_q) begin
      if (!bit_end) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
        if (bit_idx_q == BIT_LAST) begin
          active_q  <= 1'b0;
          bit_idx_q <= '0;
        end else begin
          bit_idx_q <= bit_idx_q + 4'd1;
          // frame bit n+1 carries data bit n; after data bit 7 comes the stop bit
          tx_q      <= (bit_idx_q == BIT_MSB) ? STOP_BIT : data_q[bit_idx_q[2:0]];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hex_uart_printer.sv
// ============================================================================
// Module   : hex_uart_printer
// Brief    : Accepts one word per valid/ready handshake and prints it on the
//            UART as lowercase hex, MSB nibble first, followed by CR LF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_uart_printer
  import hex_uart_printer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int WORD_NIBBLES = 4
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  hex_uart_printer_if.slave  bus
);

  localparam int                DATA_W   = 4 * WORD_NIBBLES;
  localparam int                NCHARS   = WORD_NIBBLES + 2;
  localparam int                CIDX_W   = $clog2(NCHARS);
  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NCHARS - 1);
  localparam logic [CIDX_W-1:0] CR_IDX   = CIDX_W'(WORD_NIBBLES);

  state_t            state_q;
  logic              in_ready_q;
  logic              busy_q;
  logic [DATA_W-1:0] shift_q;      // top nibble is the next digit still to be sent
  logic [CIDX_W-1:0] char_idx_q;   // index of the character currently on the wire
  logic [CIDX_W-1:0] next_idx;
  logic              accept;
  logic              byte_start;
  logic              byte_ready;
  logic [7:0]        byte_data;
  logic              tx_w;

  assign accept   = (state_q == IDLE) & in_ready_q & bus.in_valid;
  assign next_idx = char_idx_q + CIDX_W'(1);

  // Pick the character for the serialiser: first digit straight from the bus
  // on accept, later digits from the shift register, then CR and LF
  always_comb begin
    byte_start = 1'b0;
    byte_data  = nibble_to_ascii(bus.in_data[DATA_W-1 -: 4]);
    if (state_q == IDLE) begin
      byte_start = accept;
    end else begin
      byte_start = byte_ready && (char_idx_q != LAST_IDX);
      if (next_idx < CR_IDX) begin
        byte_data = nibble_to_ascii(shift_q[DATA_W-1 -: 4]);
      end else if (next_idx == CR_IDX) begin
        byte_data = ASCII_CR;
      end else begin
        byte_data = ASCII_LF;
      end
    end
  end

  // Handshake and character sequencing FSM
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      shift_q    <= '0;
      char_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q    <= bus.in_data << 4;
            char_idx_q <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SEND;
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        SEND: begin
          if (byte_ready) begin
            if (char_idx_q == LAST_IDX) begin
              char_idx_q <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              char_idx_q <= next_idx;
              if (next_idx < CR_IDX) begin
                shift_q <= shift_q << 4;
              end
            end
          end
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (byte_start),
    .data_i  (byte_data),
    .tx_o    (tx_w),
    .ready_o (byte_ready)
  );

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.tx       = tx_w;

endmodule

`default_nettype wire

// File: tb/tb_hex_uart_printer.sv
// ============================================================================
// Module   : tb_hex_uart_printer
// Brief    : Self-checking bench for hex_uart_printer. dut0 uses C=4, N=4 and
//            dut1 uses C=2, N=1. Expected text comes from a table or from
//            $sformatf hex formatting; the expected tx waveform is rebuilt
//            from the 8N1 framing rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hex_uart_printer;

  typedef struct {
    logic [15:0] word;
    string       digits;
    bit          b2b;
  } vec_t;

  logic clk;
  logic rst0;
  logic rst1;
  int   vectors;
  int   miscompares;

  hex_uart_printer_if #(.WORD_NIBBLES(4)) b0 ();
  hex_uart_printer_if #(.WORD_NIBBLES(1)) b1 ();

  hex_uart_printer #(.CLKS_PER_BIT(4), .WORD_NIBBLES(4)) dut0 (
    .clk_i (clk),
    .rst_i (rst0),
    .bus   (b0.slave)
  );

  hex_uart_printer #(.CLKS_PER_BIT(2), .WORD_NIBBLES(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst1),
    .bus   (b1.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel != 0) ? b1.in_ready : b0.in_ready;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel != 0) ? b1.busy : b0.busy;
  endfunction

  function automatic logic txs(input int sel);
    return (sel != 0) ? b1.tx : b0.tx;
  endfunction

  task automatic drive(input int sel, input logic [15:0] w, input logic v);
    if (sel != 0) begin
      b1.in_data  = w[3:0];
      b1.in_valid = v;
    end else begin
      b0.in_data  = w;
      b0.in_valid = v;
    end
  endtask

  // Called just after a negedge. Sends one word, records tx every cycle and
  // compares against the expected framing of digits + CR LF.
  task automatic run_word(input int sel, input logic [15:0] w, input string digits,
                          input bit jitter, input bit b2b);
    int         c;
    int         n;
    int         total;
    int         waited;
    int         busy_bad;
    int         wave_bad;
    logic [7:0] exp_q[$];
    logic       exp_wave[$];
    logic       got_wave[$];
    logic [7:0] got_byte;
    logic       bv;
    c        = (sel != 0) ? 2 : 4;
    n        = (sel != 0) ? 1 : 4;
    total    = (n + 2) * 10 * c;
    waited   = 0;
    busy_bad = 0;
    wave_bad = 0;
    while (rdy(sel) !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (rdy(sel) !== 1'b1) begin
      check($sformatf("ready_timeout_%0d", sel), 32'(rdy(sel)), 32'd1);
      return;
    end
    if (b2b) check("b2b_gap_cycles", 32'(waited), 32'd0);
    drive(sel, w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (!jitter) drive(sel, 16'h0, 1'b0);
    for (int i = 0; i < total; i++) begin
      got_wave.push_back(txs(sel));
      if (rdy(sel) !== 1'b0 || bsy(sel) !== 1'b1) busy_bad++;
      if (jitter) drive(sel, 16'($urandom), 1'b1);
      @(negedge clk);
    end
    drive(sel, 16'h0, 1'b0);
    // first negedge after the final stop bit: handshake back, line idle
    check($sformatf("ready_return_%0d_%s", sel, digits), 32'(rdy(sel)), 32'd1);
    check($sformatf("busy_clear_%0d_%s", sel, digits), 32'(bsy(sel)), 32'd0);
    check($sformatf("tx_idle_%0d_%s", sel, digits), 32'(txs(sel)), 32'd1);
    check($sformatf("busy_window_%0d_%s", sel, digits), 32'(busy_bad), 32'd0);
    for (int k = 0; k < digits.len(); k++) exp_q.push_back(digits[k]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    foreach (exp_q[ch]) begin
      for (int b = 0; b < 10; b++) begin
        bv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_q[ch][b-1];
        repeat (c) exp_wave.push_back(bv);
      end
      got_byte = '0;
      for (int b = 1; b <= 8; b++) got_byte[b-1] = got_wave[(ch * 10 + b) * c + c / 2];
      check($sformatf("char%0d_%0d_%s", ch, sel, digits), 32'(got_byte), 32'(exp_q[ch]));
    end
    for (int i = 0; i < total; i++) if (got_wave[i] !== exp_wave[i]) wave_bad++;
    check($sformatf("wave_cycles_%0d_%s", sel, digits), 32'(wave_bad), 32'd0);
  endtask

  initial begin
    vec_t        vecs[4];
    logic [15:0] w;
    logic [3:0]  nib;
    clk         = 1'b0;
    rst0        = 1'b1;
    rst1        = 1'b1;
    vectors     = 0;
    miscompares = 0;
    drive(0, 16'h0, 1'b0);
    drive(1, 16'h0, 1'b0);

    vecs[0] = '{word: 16'h1A2F, digits: "1a2f", b2b: 1'b0};
    vecs[1] = '{word: 16'h9A0F, digits: "9a0f", b2b: 1'b0};
    vecs[2] = '{word: 16'h0000, digits: "0000", b2b: 1'b1};
    vecs[3] = '{word: 16'hFFFF, digits: "ffff", b2b: 1'b0};

    // reset held 5 cycles: line idle, no handshake
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_tx0", 32'(b0.tx), 32'd1);
      check("rst_rdy0", 32'(b0.in_ready), 32'd0);
      check("rst_busy0", 32'(b0.busy), 32'd0);
      check("rst_tx1", 32'(b1.tx), 32'd1);
      check("rst_rdy1", 32'(b1.in_ready), 32'd0);
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    check("rdy_after_rst0", 32'(b0.in_ready), 32'd1);
    check("rdy_after_rst1", 32'(b1.in_ready), 32'd1);
    check("busy_after_rst0", 32'(b0.busy), 32'd0);

    // table: single word, digit boundaries, back-to-back pair, all-f
    for (int i = 0; i < 4; i++) run_word(0, vecs[i].word, vecs[i].digits, 1'b0, vecs[i].b2b);

    // in_valid held high with changing data while busy
    run_word(0, 16'h5C3E, "5c3e", 1'b1, 1'b0);

    // reset during the start bit of the third character
    while (b0.in_ready !== 1'b1) @(negedge clk);
    drive(0, 16'h1234, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 16'h0, 1'b0);
    repeat (80) @(negedge clk);
    check("midrst_pre_tx", 32'(b0.tx), 32'd0);
    #2 rst0 = 1'b1;
    #1;
    check("midrst_tx", 32'(b0.tx), 32'd1);
    check("midrst_rdy", 32'(b0.in_ready), 32'd0);
    check("midrst_busy", 32'(b0.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    run_word(0, 16'hBEEF, "beef", 1'b0, 1'b0);

    // N=1, C=2
    run_word(1, 16'h000C, "c", 1'b0, 1'b0);

    // randomized words against the $sformatf hex model
    repeat (5) begin
      w = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_word(0, w, $sformatf("%04h", w), 1'b0, 1'b0);
    end
    repeat (6) begin
      nib = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_word(1, {12'h0, nib}, $sformatf("%h", nib), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
